cic_measure_ctrl: RTL and testbench
===================================

CIC_MEASURE_CTRL -- requirements
Module: cic_measure_ctrl

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 16, width of CIC output samples and of result.
REQ-002 SHALL have parameter MAX_AVG_LOG2, default 8, largest log2 of the averaging count.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 4, number of cycles the CIC is held in reset at measurement start.
REQ-004 SHALL have parameter SETTLE_SAMPLES, default 3, number of CIC output samples discarded after flush.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to begin a measurement.
REQ-008 SHALL have port abort, input, 1, cancels any measurement in progress.
REQ-009 SHALL have port avg_log2, input, 4, log2 of the number of samples to average; sampled on accepted start.
REQ-010 SHALL have port cic_dout, input, OUTPUT_WIDTH, signed decimated sample from the CIC filter.
REQ-011 SHALL have port cic_valid, input, 1, qualifies cic_dout for one cycle.
REQ-012 SHALL have port cic_rst_n, output, 1, active-low reset driven to the CIC filter.
REQ-013 SHALL have port result, output, OUTPUT_WIDTH, signed averaged result.
REQ-014 SHALL have port result_valid, output, 1, result available.
REQ-015 SHALL have port result_ready, input, 1, consumer accepts result.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port overrun, output, 1, sticky flag: a cic_valid arrived while result was pending.

Function
REQ-018 SHALL implement states IDLE, FLUSH, SETTLE, ACCUM, HOLD.
REQ-019 SHALL, in IDLE, accept start=1: next cycle state FLUSH; latch N = min(avg_log2, MAX_AVG_LOG2); clear accumulator, counters and overrun.
REQ-020 SHALL drive cic_rst_n=0 for exactly FLUSH_CYCLES cycles in FLUSH, then enter SETTLE; cic_rst_n=1 in all other states.
REQ-021 SHALL, in SETTLE, discard cic_valid samples and enter ACCUM on the cycle after the SETTLE_SAMPLES-th; SETTLE_SAMPLES=0 enters ACCUM directly from FLUSH.
REQ-022 SHALL, in ACCUM, add sign-extended cic_dout into an accumulator of OUTPUT_WIDTH+MAX_AVG_LOG2 bits on each cic_valid; no overflow is possible by construction.
REQ-023 SHALL, on the 2^N-th accumulated sample, register result = (accumulator incl. that sample) arithmetic-shifted right by N, truncated to OUTPUT_WIDTH, assert result_valid the next cycle and enter HOLD.
REQ-024 SHALL, for N=0, pass the first ACCUM sample through unchanged.
REQ-025 SHALL hold result and result_valid stable in HOLD until result_valid and result_ready are both high, then enter IDLE the next cycle with result_valid=0.
REQ-026 SHALL set overrun on any cic_valid in HOLD; the sample is dropped; overrun clears only on rst or accepted start.
REQ-027 SHALL ignore start in any state other than IDLE.
REQ-028 SHALL, on abort=1 in any state, enter IDLE the next cycle, with result_valid=0 and cic_rst_n=1; result keeps its last value.
REQ-029 SHALL give abort priority over start when both are high in IDLE (remain IDLE).
REQ-030 SHALL ignore cic_valid in IDLE and FLUSH.
REQ-031 SHALL run measurement latency from start to result_valid of 1 + FLUSH_CYCLES + (settle/accum sample arrival time) + 1 cycles, with no extra pipeline stages.

Reset
REQ-032 SHALL, on rst=1 at a clock edge, set state IDLE, result=0, result_valid=0, busy=0, overrun=0, cic_rst_n=1, all counters and the accumulator 0, regardless of current state.
REQ-033 SHALL give rst priority over abort and start.

Verification
REQ-034 SHALL cover basic average: avg_log2=2, stub CIC emits 3 discard samples then 10,20,30,41 -> result=25, result_valid held until result_ready, then busy=0.
REQ-035 SHALL cover negative rounding: avg_log2=1, samples -3,-4 -> result=-4 (arithmetic shift floors).
REQ-036 SHALL cover flush timing: start at cycle t -> cic_rst_n low exactly cycles t+1..t+4; cic_valid pulses during flush not counted.
REQ-037 SHALL cover overrun: result_ready held 0, one extra cic_valid in HOLD -> overrun=1, result unchanged; the next start clears it.
REQ-038 SHALL cover abort mid-ACCUM after 2 of 4 samples -> IDLE next cycle, no result_valid; a new start then yields a correct fresh average.
REQ-039 SHALL cover reset mid-operation: rst in SETTLE -> all outputs at reset values next cycle; avg_log2=12 clamps to 8 (256 samples averaged).

Source files
------------

// File: rtl/cic_measure_ctrl.sv
// Measurement controller for a CIC decimator: flushes the filter,
// discards settling samples, then averages 2^N samples into a result.
module cic_measure_ctrl #(
  parameter int OUTPUT_WIDTH   = 16,
  parameter int MAX_AVG_LOG2   = 8,
  parameter int FLUSH_CYCLES   = 4,
  parameter int SETTLE_SAMPLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [3:0]              avg_log2,
  input  logic [OUTPUT_WIDTH-1:0] cic_dout,
  input  logic                    cic_valid,
  output logic                    cic_rst_n,
  output logic [OUTPUT_WIDTH-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [2:0] {
    IDLE, FLUSH, SETTLE, ACCUM, HOLD
  } state_t;

  localparam int AW = OUTPUT_WIDTH + MAX_AVG_LOG2;
  localparam int CW = MAX_AVG_LOG2 + 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 2);
  localparam int SW = $clog2(SETTLE_SAMPLES + 2);
  localparam logic [3:0] MAXN = 4'(MAX_AVG_LOG2);

  state_t                  state_q, state_d;
  logic [3:0]              n_q, n_d;
  logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
  logic [SW-1:0]           settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]           samp_cnt_q, samp_cnt_d;
  logic [AW-1:0]           acc_q, acc_d;
  logic [OUTPUT_WIDTH-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    overrun_q, overrun_d;

  logic [AW-1:0]        acc_sum;
  logic signed [AW-1:0] shifted;
  logic                 samp_last;

  // Accumulator is wide enough for 2^MAX_AVG_LOG2 full-scale samples
  assign acc_sum = acc_q
    + {{MAX_AVG_LOG2{cic_dout[OUTPUT_WIDTH-1]}}, cic_dout};
  assign shifted = $signed(acc_sum) >>> n_q;
  assign samp_last =
    samp_cnt_q == ((CW'(1) << n_q) - CW'(1));

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    flush_cnt_d    = flush_cnt_q;
    settle_cnt_d   = settle_cnt_q;
    samp_cnt_d     = samp_cnt_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = FLUSH;
          n_d          = (avg_log2 > MAXN) ? MAXN : avg_log2;
          flush_cnt_d  = '0;
          settle_cnt_d = '0;
          samp_cnt_d   = '0;
          acc_d        = '0;
          overrun_d    = 1'b0;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FW'(FLUSH_CYCLES - 1)) begin
          state_d = (SETTLE_SAMPLES == 0) ? ACCUM : SETTLE;
        end
      end
      SETTLE: begin
        if (cic_valid) begin
          settle_cnt_d = settle_cnt_q + SW'(1);
          if (settle_cnt_q == SW'(SETTLE_SAMPLES - 1)) begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (cic_valid) begin
          acc_d      = acc_sum;
          samp_cnt_d = samp_cnt_q + CW'(1);
          if (samp_last) begin
            result_d       = shifted[OUTPUT_WIDTH-1:0];
            result_valid_d = 1'b1;
            state_d        = HOLD;
          end
        end
      end
      HOLD: begin
        if (cic_valid) begin
          overrun_d = 1'b1;
        end
        if (result_valid_q && result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything except reset, including start in IDLE
    if (abort) begin
      state_d        = IDLE;
      result_valid_d = 1'b0;
      n_d            = n_q;
      flush_cnt_d    = flush_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      samp_cnt_d     = samp_cnt_q;
      acc_d          = acc_q;
      overrun_d      = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      flush_cnt_q    <= '0;
      settle_cnt_q   <= '0;
      samp_cnt_q     <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      flush_cnt_q    <= flush_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      samp_cnt_q     <= samp_cnt_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign cic_rst_n    = (state_q != FLUSH);
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_cic_measure_ctrl.sv
// Directed bench for cic_measure_ctrl with a hand-driven CIC stub.
module tb_cic_measure_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  avg_log2;
  logic [15:0] cic_dout;
  logic        cic_valid;
  logic        cic_rst_n;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_measure_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .avg_log2(avg_log2), .cic_dout(cic_dout),
    .cic_valid(cic_valid), .cic_rst_n(cic_rst_n),
    .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .busy(busy),
    .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic sample(input int v);
    cic_dout  = 16'(v);
    cic_valid = 1'b1;
    tick();
    cic_valid = 1'b0;
    tick();
  endtask

  task automatic go(input logic [3:0] n);
    avg_log2 = n;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic flush_and_settle();
    repeat (4) tick();
    repeat (3) sample(16'h0100);
  endtask

  task automatic accept();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    avg_log2 = 4'd0; cic_dout = '0; cic_valid = 1'b0;
    result_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_rv", 32'(result_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_cicrstn", 32'(cic_rst_n), 32'h1);

    // basic average with flush timing; valid during flush ignored
    go(4'd2);
    for (int i = 0; i < 4; i++) begin
      chk("flush_low", 32'(cic_rst_n), 32'h0);
      cic_dout  = 16'd999;
      cic_valid = (i == 1);
      tick();
      cic_valid = 1'b0;
    end
    chk("flush_end", 32'(cic_rst_n), 32'h1);
    chk("flush_busy", 32'(busy), 32'h1);
    repeat (3) sample(16'h0100);
    sample(10); sample(20); sample(30);
    chk("basic_pre_rv", 32'(result_valid), 32'h0);
    sample(41);
    chk("basic_rv", 32'(result_valid), 32'h1);
    chk("basic_res", 32'(result), 32'd25);
    repeat (3) tick();
    chk("basic_hold_rv", 32'(result_valid), 32'h1);
    chk("basic_hold_res", 32'(result), 32'd25);
    accept();
    chk("basic_acc_rv", 32'(result_valid), 32'h0);
    chk("basic_acc_busy", 32'(busy), 32'h0);

    // negative values floor
    go(4'd1);
    flush_and_settle();
    sample(-3); sample(-4);
    chk("neg_rv", 32'(result_valid), 32'h1);
    chk("neg_res", 32'(result), 32'h0000FFFC);
    accept();

    // N=0 passthrough, then overrun in HOLD
    go(4'd0);
    flush_and_settle();
    sample(77);
    chk("n0_res", 32'(result), 32'd77);
    chk("n0_ovr0", 32'(overrun), 32'h0);
    sample(5);
    chk("ovr_set", 32'(overrun), 32'h1);
    chk("ovr_res", 32'(result), 32'd77);
    chk("ovr_rv", 32'(result_valid), 32'h1);
    accept();
    chk("ovr_sticky", 32'(overrun), 32'h1);
    chk("ovr_idle", 32'(busy), 32'h0);

    // start ignored-ness of abort+start in IDLE
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_prio", 32'(busy), 32'h0);
    chk("abort_prio_ovr", 32'(overrun), 32'h1);

    // start clears overrun; abort after 2 of 4 samples
    go(4'd2);
    chk("ovr_clear", 32'(overrun), 32'h0);
    flush_and_settle();
    sample(1000); sample(2000);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rv", 32'(result_valid), 32'h0);
    chk("abort_cicrstn", 32'(cic_rst_n), 32'h1);
    chk("abort_res", 32'(result), 32'd77);
    go(4'd2);
    flush_and_settle();
    sample(1); sample(2); sample(3); sample(6);
    chk("fresh_rv", 32'(result_valid), 32'h1);
    chk("fresh_res", 32'(result), 32'd3);
    accept();

    // reset during SETTLE
    go(4'd12);
    repeat (4) tick();
    sample(16'h0100);
    chk("settle_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_res", 32'(result), 32'h0);
    chk("mrst_rv", 32'(result_valid), 32'h0);
    chk("mrst_cicrstn", 32'(cic_rst_n), 32'h1);
    chk("mrst_ovr", 32'(overrun), 32'h0);

    // avg_log2=12 clamps to 256 samples: sum 0..255 = 32640
    go(4'd12);
    flush_and_settle();
    for (int i = 0; i < 255; i++) sample(i);
    chk("clamp_pre_rv", 32'(result_valid), 32'h0);
    chk("clamp_pre_busy", 32'(busy), 32'h1);
    sample(255);
    chk("clamp_rv", 32'(result_valid), 32'h1);
    chk("clamp_res", 32'(result), 32'd127);
    accept();
    chk("clamp_done", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
